// File: rtl/ftoi_pipe.sv
// Two-stage pipelined float32 to signed/unsigned integer converter.
// Stage 1 aligns the significand; stage 2 rounds, saturates and raises flags.
module ftoi_pipe #(
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [1:0]       in_rm,
  input  logic             in_uns,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             out_nv,
  output logic             out_nx,
  output logic [TAG_W-1:0] out_tag
);

  localparam int IW = OUT_W + 1;
  localparam int SW = OUT_W + 24;
  localparam int MW = OUT_W + 2;

  localparam logic signed [8:0] BIG_E = 9'(OUT_W + 1);

  localparam logic [OUT_W-1:0] UMAX = '1;
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [MW-1:0] UMAX_M = {2'b00, UMAX};
  localparam logic [MW-1:0] SMAX_M = {2'b00, SMAX};
  localparam logic [MW-1:0] SMIN_M = {2'b00, SMIN};

  logic s1_ready;
  logic s2_ready;

  logic              s1_valid_q;
  logic              s1_sgn_q;
  logic              s1_nan_q;
  logic              s1_inf_q;
  logic              s1_big_q;
  logic [IW-1:0]     s1_int_q;
  logic              s1_grd_q;
  logic              s1_stk_q;
  logic [1:0]        s1_rm_q;
  logic              s1_uns_q;
  logic [TAG_W-1:0]  s1_tag_q;

  logic              out_valid_q;
  logic [OUT_W-1:0]  out_y_q;
  logic              out_nv_q;
  logic              out_nx_q;
  logic [TAG_W-1:0]  out_tag_q;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  // ---- stage 1: classify and align ----
  logic [7:0]        a_e;
  logic [22:0]       a_m;
  logic signed [8:0] a_exp;
  logic              a_nan;
  logic              a_inf;
  logic              a_zero;
  logic              a_tiny;
  logic              a_big;
  logic [SW-1:0]     a_wide;
  logic [IW-1:0]     s1_int_d;
  logic              s1_grd_d;
  logic              s1_stk_d;

  assign a_e    = in_x[30:23];
  assign a_m    = in_x[22:0];
  assign a_exp  = $signed({1'b0, a_e}) - 9'sd127;
  assign a_nan  = (a_e == 8'hFF) && (a_m != '0);
  assign a_inf  = (a_e == 8'hFF) && (a_m == '0);
  assign a_zero = (a_e == 8'h00);
  assign a_tiny = (a_exp < 9'sd0);
  assign a_big  = (a_exp >= BIG_E);
  assign a_wide = SW'({1'b1, a_m}) << a_exp[6:0];

  always_comb begin
    s1_int_d = '0;
    s1_grd_d = 1'b0;
    s1_stk_d = 1'b0;
    if (a_zero || a_nan || a_inf || a_big) begin
      s1_int_d = '0;
    end else if (a_tiny) begin
      // |x| < 1: only x in [0.5,1) can reach the guard position
      s1_grd_d = (a_exp == -9'sd1);
      s1_stk_d = (a_exp == -9'sd1) ? (a_m != '0) : 1'b1;
    end else begin
      s1_int_d = a_wide[SW-1:23];
      s1_grd_d = a_wide[22];
      s1_stk_d = (a_wide[21:0] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_big_q   <= 1'b0;
      s1_int_q   <= '0;
      s1_grd_q   <= 1'b0;
      s1_stk_q   <= 1'b0;
      s1_rm_q    <= 2'b00;
      s1_uns_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sgn_q <= in_x[31];
        s1_nan_q <= a_nan;
        s1_inf_q <= a_inf;
        s1_big_q <= a_big && !a_nan && !a_inf;
        s1_int_q <= s1_int_d;
        s1_grd_q <= s1_grd_d;
        s1_stk_q <= s1_stk_d;
        s1_rm_q  <= in_rm;
        s1_uns_q <= in_uns;
        s1_tag_q <= in_tag;
      end
    end
  end

  // ---- stage 2: round, apply sign, saturate ----
  logic          inc;
  logic          inexact;
  logic [MW-1:0] mag;
  logic [MW-1:0] neg_mag;
  logic [OUT_W-1:0] y_d;
  logic          nv_d;
  logic          nx_d;

  assign inexact = s1_grd_q || s1_stk_q;

  always_comb begin
    inc = 1'b0;
    unique case (s1_rm_q)
      2'b00:   inc = s1_grd_q && (s1_stk_q || s1_int_q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = s1_sgn_q && inexact;
      2'b11:   inc = !s1_sgn_q && inexact;
      default: inc = 1'b0;
    endcase
  end

  assign mag     = MW'(s1_int_q) + MW'(inc);
  assign neg_mag = ~mag + MW'(1);

  always_comb begin
    y_d  = '0;
    nv_d = 1'b0;
    nx_d = 1'b0;
    if (s1_nan_q) begin
      y_d  = s1_uns_q ? UMAX : SMAX;
      nv_d = 1'b1;
    end else if (s1_inf_q || s1_big_q) begin
      nv_d = 1'b1;
      if (s1_uns_q) y_d = s1_sgn_q ? '0 : UMAX;
      else          y_d = s1_sgn_q ? SMIN : SMAX;
    end else if (s1_uns_q && s1_sgn_q) begin
      // negative to unsigned is only legal when it rounds to zero
      if (mag != '0) nv_d = 1'b1;
      else           nx_d = inexact;
    end else if (s1_uns_q) begin
      if (mag > UMAX_M) begin
        y_d  = UMAX;
        nv_d = 1'b1;
      end else begin
        y_d  = mag[OUT_W-1:0];
        nx_d = inexact;
      end
    end else if (!s1_sgn_q) begin
      if (mag > SMAX_M) begin
        y_d  = SMAX;
        nv_d = 1'b1;
      end else begin
        y_d  = mag[OUT_W-1:0];
        nx_d = inexact;
      end
    end else begin
      if (mag > SMIN_M) begin
        y_d  = SMIN;
        nv_d = 1'b1;
      end else begin
        y_d  = neg_mag[OUT_W-1:0];
        nx_d = inexact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_nv_q    <= 1'b0;
      out_nx_q    <= 1'b0;
      out_tag_q   <= '0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_y_q   <= y_d;
        out_nv_q  <= nv_d;
        out_nx_q  <= nx_d;
        out_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_nv    = out_nv_q;
  assign out_nx    = out_nx_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: directed vectors, randomized streams with
// backpressure, reset while busy, and a 64-bit instance.
module tb_ftoi_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        a_valid, a_iready, a_ovalid, a_oready, a_uns, a_nv, a_nx;
  logic [31:0] a_x, a_y;
  logic [1:0]  a_rm;
  logic [4:0]  a_tag, a_otag;

  logic        b_valid, b_iready, b_ovalid, b_oready, b_uns, b_nv, b_nx;
  logic [31:0] b_x;
  logic [63:0] b_y;
  logic [1:0]  b_rm;
  logic [4:0]  b_tag, b_otag;

  int n_checks = 0;
  int n_fail   = 0;

  ftoi_pipe #(.OUT_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_iready),
    .in_x(a_x), .in_rm(a_rm), .in_uns(a_uns), .in_tag(a_tag),
    .out_valid(a_ovalid), .out_ready(a_oready),
    .out_y(a_y), .out_nv(a_nv), .out_nx(a_nx), .out_tag(a_otag)
  );

  ftoi_pipe #(.OUT_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_iready),
    .in_x(b_x), .in_rm(b_rm), .in_uns(b_uns), .in_tag(b_tag),
    .out_valid(b_ovalid), .out_ready(b_oready),
    .out_y(b_y), .out_nv(b_nv), .out_nx(b_nx), .out_tag(b_otag)
  );

  typedef struct packed {
    logic [31:0] x;
    logic [1:0]  rm;
    logic        uns;
    logic [63:0] y;
    logic        nv;
    logic        nx;
  } vec_t;

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic        nx;
    logic [4:0]  tag;
  } res_t;

  // Reference: exact value q + rem/2^n, rounded, then clamped to the range.
  function automatic void ref_conv(input logic [31:0] x, input logic [1:0] rm,
                                   input logic uns, input int w,
                                   output logic [63:0] y, output logic nv,
                                   output logic nx);
    logic s;
    int e, n;
    logic [127:0] sig, q, rem, half, mag;
    logic inexact, above, tie, inc;
    logic signed [129:0] v, lo, hi;
    s   = x[31];
    e   = int'(x[30:23]);
    sig = 128'(x[22:0]) | (128'd1 << 23);
    lo  = uns ? '0 : -(130'sd1 <<< (w - 1));
    hi  = uns ? (130'sd1 <<< w) - 1 : (130'sd1 <<< (w - 1)) - 1;
    nv = 1'b0; nx = 1'b0; v = '0;
    inexact = 1'b0; above = 1'b0; tie = 1'b0; q = '0; inc = 1'b0;
    if (e == 255) begin
      nv = 1'b1;
      v  = (x[22:0] == 0 && s) ? lo : hi;
    end else if (e != 0) begin
      n = 150 - e;
      if (n <= 0) begin
        q = sig << (-n);
      end else if (n > 100) begin
        q = '0;
        inexact = 1'b1;
      end else begin
        q    = sig >> n;
        rem  = sig - (q << n);
        half = 128'd1 << (n - 1);
        above   = rem > half;
        tie     = rem == half;
        inexact = rem != 0;
      end
      case (rm)
        2'd0:    inc = above | (tie & q[0]);
        2'd1:    inc = 1'b0;
        2'd2:    inc = s & inexact;
        default: inc = !s & inexact;
      endcase
      mag = q + 128'(inc);
      v = s ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
      if (v < lo) begin
        v = lo; nv = 1'b1;
      end else if (v > hi) begin
        v = hi; nv = 1'b1;
      end else begin
        nx = inexact;
      end
    end
    y = v[63:0];
    if (w < 64) y = y & ((64'd1 << w) - 1);
  endfunction

  function automatic logic [31:0] rand_x(input int w);
    logic [31:0] x;
    int p;
    x = $urandom;
    p = $urandom_range(0, 9);
    if (p == 1) begin
      x[30:23] = 8'hFF;
    end else if (p == 2) begin
      x[30:23] = 8'h00;
    end else if (p > 2) begin
      x[30:23] = 8'(120 + $urandom_range(0, w + 10));
      if (p < 5) x[15:0] = '0;
    end
    return x;
  endfunction

  task automatic xfer32(input logic [31:0] x, input logic [1:0] rm,
                        input logic uns, input logic [4:0] tag,
                        output logic [31:0] y, output logic nv,
                        output logic nx, output logic [4:0] otag,
                        output int lat);
    lat = -1; y = '0; nv = 1'b0; nx = 1'b0; otag = '0;
    @(negedge clk);
    a_x = x; a_rm = rm; a_uns = uns; a_tag = tag;
    a_valid = 1'b1; a_oready = 1'b1;
    #1;
    if (a_iready) begin
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        a_valid = 1'b0;
        if (a_ovalid) begin
          y = a_y; nv = a_nv; nx = a_nx; otag = a_otag; lat = c;
          break;
        end
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic xfer64(input logic [31:0] x, input logic [1:0] rm,
                        input logic uns, input logic [4:0] tag,
                        output logic [63:0] y, output logic nv,
                        output logic nx, output logic [4:0] otag,
                        output int lat);
    lat = -1; y = '0; nv = 1'b0; nx = 1'b0; otag = '0;
    @(negedge clk);
    b_x = x; b_rm = rm; b_uns = uns; b_tag = tag;
    b_valid = 1'b1; b_oready = 1'b1;
    #1;
    if (b_iready) begin
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        b_valid = 1'b0;
        if (b_ovalid) begin
          y = b_y; nv = b_nv; nx = b_nx; otag = b_otag; lat = c;
          break;
        end
      end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_ovalid !== 1'b0 || b_ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b/%b want 0/0", a_ovalid, b_ovalid);
    end
    n_checks++;
    if ({a_y, a_nv, a_nx, a_otag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got y=%h nv=%b nx=%b tag=%h want all 0",
               a_y, a_nv, a_nx, a_otag);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (a_iready !== 1'b1 || b_iready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b want 1/1", a_iready, b_iready);
    end
  endtask

  task automatic test_directed32();
    vec_t tbl [16];
    logic [31:0] y;
    logic nv, nx;
    logic [4:0] tg;
    int lat;
    tbl = '{
      '{32'h40200000, 2'd0, 1'b0, 64'h2,        1'b0, 1'b1},
      '{32'h40200000, 2'd1, 1'b0, 64'h2,        1'b0, 1'b1},
      '{32'h40200000, 2'd3, 1'b0, 64'h3,        1'b0, 1'b1},
      '{32'hC0200000, 2'd2, 1'b0, 64'hFFFFFFFD, 1'b0, 1'b1},
      '{32'hBF000000, 2'd0, 1'b0, 64'h0,        1'b0, 1'b1},
      '{32'h4F000000, 2'd0, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hCF000000, 2'd0, 1'b0, 64'h80000000, 1'b0, 1'b0},
      '{32'h4F000000, 2'd0, 1'b1, 64'h80000000, 1'b0, 1'b0},
      '{32'h7F800000, 2'd0, 1'b1, 64'hFFFFFFFF, 1'b1, 1'b0},
      '{32'h7FC00000, 2'd0, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h7FC00000, 2'd0, 1'b1, 64'hFFFFFFFF, 1'b1, 1'b0},
      '{32'hBF800000, 2'd0, 1'b1, 64'h0,        1'b1, 1'b0},
      '{32'hBF000000, 2'd1, 1'b1, 64'h0,        1'b0, 1'b1},
      '{32'h00000001, 2'd0, 1'b0, 64'h0,        1'b0, 1'b0},
      '{32'h80000000, 2'd0, 1'b0, 64'h0,        1'b0, 1'b0},
      '{32'hFF800000, 2'd3, 1'b0, 64'h80000000, 1'b1, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      xfer32(tbl[i].x, tbl[i].rm, tbl[i].uns, 5'(i), y, nv, nx, tg, lat);
      n_checks++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL d32_latency[%0d]: got %0d want 2", i, lat);
      end
      n_checks++;
      if (y !== tbl[i].y[31:0]) begin
        n_fail++;
        $display("FAIL d32_y[%0d] x=%h: got %h want %h", i, tbl[i].x, y,
                 tbl[i].y[31:0]);
      end
      n_checks++;
      if ({nv, nx} !== {tbl[i].nv, tbl[i].nx}) begin
        n_fail++;
        $display("FAIL d32_flags[%0d] x=%h: got nv=%b nx=%b want nv=%b nx=%b",
                 i, tbl[i].x, nv, nx, tbl[i].nv, tbl[i].nx);
      end
      n_checks++;
      if (tg !== 5'(i)) begin
        n_fail++;
        $display("FAIL d32_tag[%0d]: got %0d want %0d", i, tg, i);
      end
    end
  endtask

  task automatic run_stream(input int n, input bit rnd);
    res_t q[$];
    res_t e, held;
    int sent, got, infl, cyc;
    logic stall, took;
    logic [63:0] my;
    logic mnv, mnx;
    sent = 0; got = 0; infl = 0; cyc = 0;
    stall = 1'b0; took = 1'b1; held = '0;
    while (got < n && cyc < 40 * n + 50) begin
      @(negedge clk);
      if (!a_valid || took) begin
        if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
          a_valid = 1'b1;
          a_x     = rand_x(32);
          a_rm    = 2'($urandom_range(0, 3));
          a_uns   = 1'($urandom_range(0, 1));
          a_tag   = 5'(sent);
        end else begin
          a_valid = 1'b0;
        end
      end
      a_oready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 6 && cyc <= 8);
      #1;
      n_checks++;
      if (a_iready !== !(infl == 2 && !a_oready)) begin
        n_fail++;
        $display("FAIL in_ready cyc=%0d: got %b want %b (in flight %0d)",
                 cyc, a_iready, !(infl == 2 && !a_oready), infl);
      end
      if (stall) begin
        n_checks++;
        if ({a_ovalid, a_y, a_nv, a_nx, a_otag} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: got v=%b %h want v=1 %h",
                   cyc, a_ovalid, {a_y, a_nv, a_nx, a_otag}, held);
        end
      end
      if (a_ovalid && a_oready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output cyc=%0d: got tag %0d want none",
                   cyc, a_otag);
        end else begin
          e = q.pop_front();
          if ({a_y, a_nv, a_nx, a_otag} !== e) begin
            n_fail++;
            $display("FAIL stream_result: got y=%h nv=%b nx=%b tag=%0d want y=%h nv=%b nx=%b tag=%0d",
                     a_y, a_nv, a_nx, a_otag, e.y, e.nv, e.nx, e.tag);
          end
        end
        got++;
        infl--;
      end
      if (a_valid && a_iready) begin
        ref_conv(a_x, a_rm, a_uns, 32, my, mnv, mnx);
        q.push_back({my[31:0], mnv, mnx, a_tag});
        sent++;
        infl++;
      end
      took  = a_valid && a_iready;
      stall = a_ovalid && !a_oready;
      held  = {a_y, a_nv, a_nx, a_otag};
      cyc++;
    end
    a_valid  = 1'b0;
    a_oready = 1'b1;
    n_checks++;
    if (got != n || q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results want %0d (%0d pending)",
               got, n, q.size());
    end
  endtask

  task automatic test_backpressure();
    run_stream(8, 1'b0);
  endtask

  task automatic test_random();
    run_stream(300, 1'b1);
  endtask

  task automatic test_reset_inflight();
    int seen;
    @(negedge clk);
    a_oready = 1'b0;
    a_valid = 1'b1; a_x = 32'h40400000; a_rm = 2'd0; a_uns = 1'b0;
    a_tag = 5'd20;
    @(posedge clk);
    @(negedge clk);
    a_tag = 5'd21;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (a_ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_valid: got %b want 0", a_ovalid);
    end
    n_checks++;
    if ({a_y, a_nv, a_nx, a_otag} !== '0) begin
      n_fail++;
      $display("FAIL rst_busy_outs: got y=%h nv=%b nx=%b tag=%h want all 0",
               a_y, a_nv, a_nx, a_otag);
    end
    rst = 1'b0;
    a_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (a_iready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_in_ready: got %b want 1", a_iready);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (a_ovalid && (a_otag == 5'd20 || a_otag == 5'd21)) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_busy_dropped: got %0d dropped tags seen want 0", seen);
    end
  endtask

  task automatic test_out_w64();
    vec_t tbl [3];
    logic [63:0] y, my;
    logic nv, nx, mnv, mnx;
    logic [4:0] tg;
    logic [31:0] x;
    logic [1:0] rm;
    logic uns;
    int lat;
    tbl = '{
      '{32'h5F000000, 2'd0, 1'b0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0},
      '{32'h3FC00000, 2'd0, 1'b0, 64'h2,                1'b0, 1'b1},
      '{32'h5F000000, 2'd0, 1'b1, 64'h8000000000000000, 1'b0, 1'b0}
    };
    for (int i = 0; i < 3; i++) begin
      xfer64(tbl[i].x, tbl[i].rm, tbl[i].uns, 5'(i), y, nv, nx, tg, lat);
      n_checks++;
      if (y !== tbl[i].y || {nv, nx} !== {tbl[i].nv, tbl[i].nx}
          || lat !== 2) begin
        n_fail++;
        $display("FAIL d64[%0d] x=%h: got y=%h nv=%b nx=%b lat=%0d want y=%h nv=%b nx=%b lat=2",
                 i, tbl[i].x, y, nv, nx, lat, tbl[i].y, tbl[i].nv, tbl[i].nx);
      end
    end
    for (int i = 0; i < 60; i++) begin
      x   = rand_x(64);
      rm  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      ref_conv(x, rm, uns, 64, my, mnv, mnx);
      xfer64(x, rm, uns, 5'(i), y, nv, nx, tg, lat);
      n_checks++;
      if (y !== my || {nv, nx} !== {mnv, mnx} || tg !== 5'(i)) begin
        n_fail++;
        $display("FAIL r64[%0d] x=%h rm=%0d uns=%b: got y=%h nv=%b nx=%b tag=%0d want y=%h nv=%b nx=%b tag=%0d",
                 i, x, rm, uns, y, nv, nx, tg, my, mnv, mnx, i);
      end
    end
  endtask

  initial begin
    a_valid = 1'b0; a_oready = 1'b1; a_x = '0; a_rm = '0; a_uns = 1'b0;
    a_tag = '0;
    b_valid = 1'b0; b_oready = 1'b1; b_x = '0; b_rm = '0; b_uns = 1'b0;
    b_tag = '0;
    test_reset();
    test_directed32();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_out_w64();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined, parametrised float32-to-integer converter for the FPU issue path: successor to the combinational single-mode converter.
- Adds output width OUT_W, signed/unsigned target, four rounding modes, IEEE invalid/inexact flags, and valid/ready handshake with a transaction tag.
- Two register stages, one op/cycle throughput, full backpressure.

Parameters:
- OUT_W, 32, integer result width; legal values 32..64.
- TAG_W, 5, width of the opaque tag carried alongside each op.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  converter can accept request
- in_x  in  32  IEEE-754 single operand
- in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (floor), 11 RUP (ceil)
- in_uns  in  1  1 = unsigned target, 0 = signed two's complement
- in_tag  in  TAG_W  tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  OUT_W  integer result
- out_nv  out  1  invalid flag
- out_nx  out  1  inexact flag
- out_tag  out  TAG_W  tag of this result

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: s1_valid = s2_valid = 0; out_valid = 0; out_y, out_nv, out_nx, out_tag = 0. In-flight ops are dropped, not completed. in_ready = 1 in the cycle after reset deasserts.
- Stage 1 (decode/shift):
  - Split s/e/m. E = e − 127 (signed, 9 bit).
  - Significand {1,m} is aligned into integer part (OUT_W+1 bits) plus guard bit and sticky bit.
  - Class flags: nan, inf, zero (e == 0; denormals are flushed to zero, nx = 0), tiny (E < 0), big (E ≥ OUT_W+1).
- Stage 2 (round/saturate):
  - Rounding increment:
    - RNE: guard & (sticky | lsb)
    - RTZ: 0
    - RDN: s & (guard | sticky)
    - RUP: !s & (guard | sticky)
  - Magnitude = int + inc. Apply sign (two's complement if s).
  - Range check on the signed rounded value:
    - signed: [−2^(OUT_W−1), 2^(OUT_W−1)−1]
    - unsigned: [0, 2^OUT_W−1]
  - Out of range: saturate to the nearest bound; nv = 1, nx = 0.
  - NaN: result is signed max (0 sign bit, rest 1s) or, for unsigned, all ones; nv = 1.
  - ±Inf: saturate per sign; nv = 1.
  - Unsigned target with negative input: nv = 1 and result 0 only if the rounded value is nonzero; otherwise result 0, nx = (guard | sticky), nv = 0.
  - In-range result: nx = guard | sticky; nv = 0. nv and nx are never both 1.
- Handshake:
  - s2_ready = !s2_valid | out_ready; s1_ready = !s1_valid | s2_ready; in_ready = s1_ready (combinational, no dependence on in_valid).
  - Transfer on valid & ready on each side.
  - Latency is 2 cycles from input transfer to out_valid when unstalled.
  - While out_valid & !out_ready: out_y, out_nv, out_nx, out_tag hold stable and out_valid stays 1.
  - Order is preserved; no drop or duplication.
- Simultaneous in-transfer and out-transfer with both stages full is legal and keeps full throughput.
- Stage-2 registers load only when s2_ready.
- Zero result is +0 encoding; −0.0 input gives 0, nv = 0, nx = 0.

Test Plan:
- OUT_W = 32, signed, 0x40200000 (2.5):
  - RNE → 2, nx = 1
  - RTZ → 2
  - RUP → 3
  - 0xC0200000 (−2.5) RDN → 0xFFFFFFFD, nx = 1
  - 0xBF000000 (−0.5) RNE → 0, nx = 1
- Saturation:
  - 0x4F000000 (2^31) signed → 0x7FFFFFFF, nv = 1
  - 0xCF000000 signed → 0x80000000, nv = 0, nx = 0
  - 0x4F000000 unsigned → 0x80000000, nv = 0
  - 0x7F800000 unsigned → 0xFFFFFFFF, nv = 1
- Specials:
  - 0x7FC00000 signed → 0x7FFFFFFF, nv = 1; unsigned → 0xFFFFFFFF, nv = 1
  - 0xBF800000 (−1.0) unsigned → 0, nv = 1
  - 0xBF000000 unsigned RTZ → 0, nv = 0, nx = 1
  - 0x00000001 → 0, flags 0
- Backpressure: 8 back-to-back ops tagged 0..7, out_ready low for 3 cycles mid-stream:
  - outputs arrive in tag order 0..7, none lost or duplicated
  - out_* stable while stalled
  - in_ready drops only once both stages are full
- Reset with 2 ops in flight:
  - next cycle out_valid = 0 and all outputs are 0
  - in_ready = 1
  - the dropped tags never appear at the output
- OUT_W = 64:
  - 0x5F000000 (2^63) signed → 0x7FFFFFFFFFFFFFFF, nv = 1
  - 0x3FC00000 (1.5) RNE → 2, nx = 1
  - 0x5F000000 unsigned → 0x8000000000000000, flags 0
